// File: rtl/instruction_prefetch_pkg.sv
// Shared types and sizing helpers for the instruction prefetch stage:
// fetch FSM encodings, queue entry width and occupancy counter width.
package instruction_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // Occupancy counter needs one extra bit so a full queue (count == DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int entry_width(input int i_width, input int pc_width);
        return i_width + pc_width;
    endfunction

endpackage

// File: rtl/instruction_prefetch_if.sv
// Fetch-stage bus: instruction memory request/ack, redirect input and decode valid/stall.
// Optional macro FETCH_MISALIGN_EN adds the sticky o_misaligned flag.
interface instruction_prefetch_if #(
    parameter int I_WIDTH  = 32,
    parameter int A_WIDTH  = 32,
    parameter int PC_WIDTH = 32
);
    logic                o_syn;
    logic [A_WIDTH-1:0]  o_addr_instr;
    logic                i_ack;
    logic [I_WIDTH-1:0]  i_instr;
    logic                change_pc;
    logic [PC_WIDTH-1:0] alu_pc_value;
    logic                o_ce;
    logic [I_WIDTH-1:0]  o_instr;
    logic [PC_WIDTH-1:0] pc;
    logic                i_stall;
`ifdef FETCH_MISALIGN_EN
    logic                o_misaligned;

    modport master (
        output o_syn, o_addr_instr, o_ce, o_instr, pc, o_misaligned,
        input  i_ack, i_instr, change_pc, alu_pc_value, i_stall
    );

    modport slave (
        input  o_syn, o_addr_instr, o_ce, o_instr, pc, o_misaligned,
        output i_ack, i_instr, change_pc, alu_pc_value, i_stall
    );
`else
    modport master (
        output o_syn, o_addr_instr, o_ce, o_instr, pc,
        input  i_ack, i_instr, change_pc, alu_pc_value, i_stall
    );

    modport slave (
        input  o_syn, o_addr_instr, o_ce, o_instr, pc,
        output i_ack, i_instr, change_pc, alu_pc_value, i_stall
    );
`endif
endinterface

// File: rtl/instruction_prefetch_queue.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs; pointers wrap mod DEPTH,
// flush empties the queue in one cycle and takes priority over push/pop.
module instruction_prefetch_queue
    import instruction_prefetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             f_clk,
    input  logic             f_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && !flush && (count_reg != '0);
    assign push_ok = push && !flush && ((count_reg != FULL_COUNT) || pop_ok);

    always_ff @(posedge f_clk or posedge f_rst) begin
        if (f_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: an empty queue never exposes its contents.
    always_ff @(posedge f_clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instruction_prefetch.sv
// Fetch stage: issues sequential instruction fetches ahead of decode into a prefetch queue,
// handles redirects (flush + new PC) and drops stale responses. Macro FETCH_MISALIGN_EN enables o_misaligned.
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int                  I_WIDTH  = 32,
    parameter int                  A_WIDTH  = 32,
    parameter int                  PC_WIDTH = 32,
    parameter int                  DEPTH    = 4,
    parameter int                  PC_STEP  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   f_clk,
    input  logic                   f_rst,
    instruction_prefetch_if.master bus
);
    localparam int CW = count_width(DEPTH);
    localparam int EW = entry_width(I_WIDTH, PC_WIDTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_state_t        state_reg;
    logic [PC_WIDTH-1:0] fetch_pc_reg;
    logic [A_WIDTH-1:0]  req_addr_reg;
    logic                syn_reg;

    logic [CW-1:0]       count;
    logic [EW-1:0]       head;
    logic                push;
    logic                pop;
    logic                valid;
    logic [CW-1:0]       count_after;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                redirect_bad;
    logic                issue_ok;

    // A redirect cancels any push or pop in the same cycle; the queue flushes instead.
    assign valid       = (count != '0);
    assign push        = (state_reg == ST_REQ) && bus.i_ack && !bus.change_pc;
    assign pop         = valid && !bus.i_stall && !bus.change_pc;
    assign count_after = count + CW'(push) - CW'(pop);
    assign pc_inc      = fetch_pc_reg + PC_WIDTH'(PC_STEP);

`ifdef FETCH_MISALIGN_EN
    logic misalign_reg;

    assign redirect_pc  = bus.alu_pc_value;
    assign redirect_bad = (bus.alu_pc_value[1:0] != 2'b00);
    assign issue_ok     = (count != FULL_COUNT) && !misalign_reg;

    // Sticky until the next redirect lands on an aligned target.
    always_ff @(posedge f_clk or posedge f_rst) begin
        if (f_rst) begin
            misalign_reg <= 1'b0;
        end else if (bus.change_pc) begin
            misalign_reg <= redirect_bad;
        end
    end

    assign bus.o_misaligned = misalign_reg;
`else
    assign redirect_pc  = bus.alu_pc_value & ~PC_WIDTH'(3);
    assign redirect_bad = 1'b0;
    assign issue_ok     = (count != FULL_COUNT);
`endif

    instruction_prefetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .f_clk     (f_clk),
        .f_rst     (f_rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.change_pc),
        .push_data ({fetch_pc_reg, bus.i_instr}),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge f_clk or posedge f_rst) begin
        if (f_rst) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= '0;
            syn_reg      <= 1'b0;
        end else if (bus.change_pc) begin
            fetch_pc_reg <= redirect_pc;
            if (redirect_bad) begin
                state_reg <= ST_IDLE;
                syn_reg   <= 1'b0;
            end else if (state_reg != ST_IDLE && !bus.i_ack) begin
                // Request still in flight: keep presenting it and throw its data away.
                state_reg <= ST_DISCARD;
            end else begin
                // Nothing outstanding any more, so the target can be requested right away.
                state_reg    <= ST_REQ;
                syn_reg      <= 1'b1;
                req_addr_reg <= redirect_pc[A_WIDTH-1:0];
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue_ok) begin
                        state_reg    <= ST_REQ;
                        syn_reg      <= 1'b1;
                        req_addr_reg <= fetch_pc_reg[A_WIDTH-1:0];
                    end
                end
                ST_REQ: begin
                    if (bus.i_ack) begin
                        fetch_pc_reg <= pc_inc;
                        if (count_after != FULL_COUNT) begin
                            req_addr_reg <= pc_inc[A_WIDTH-1:0];
                        end else begin
                            state_reg <= ST_IDLE;
                            syn_reg   <= 1'b0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (bus.i_ack) begin
                        state_reg    <= ST_REQ;
                        req_addr_reg <= fetch_pc_reg[A_WIDTH-1:0];
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    syn_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_syn        = syn_reg;
    assign bus.o_addr_instr = req_addr_reg;
    assign bus.o_ce         = valid;
    assign bus.o_instr      = valid ? head[I_WIDTH-1:0] : '0;
    assign bus.pc           = valid ? head[EW-1:I_WIDTH] : '0;

endmodule
